scan_index_sequencer: RTL and testbench



---
 rtl/scan_index_sequencer.sv | 178 +++++++++++++++++
 tb/tb_scan_index_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_index_sequencer.sv
// Steps a 4-bit decoder select through the enabled channels of a mask, holding each for dwell+1 cycles.
// Latency: first a_vld one cycle after start; every output is registered. No backpressure: stop aborts, start is ignored while busy.
// Optional SCAN_BLANK_EN: inserts one a_vld=0 cycle on every in-scan index change (break-before-make).
module scan_index_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               cont,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [15:0]        mask,
  output logic [3:0]         a,
  output logic               a_vld,
  output logic               busy,
  output logic               done,
  output logic               wrap
);

  typedef enum logic [1:0] {
    IDLE,
`ifdef SCAN_BLANK_EN
    BLANK,
`endif
    DWELL
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         a_q, a_d;
  logic               a_vld_q, a_vld_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               wrap_q, wrap_d;
  logic               cont_q, cont_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [15:0]        higher;
  logic [3:0]         nxt_idx;
  logic               nxt_wrap;
  logic               to_idle;
`ifdef SCAN_BLANK_EN
  logic [3:0]         pend_idx_q, pend_idx_d;
  logic               pend_wrap_q, pend_wrap_d;
`endif

  function automatic logic [3:0] lowest(input logic [15:0] m);
    logic [3:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i]) r = 4'(i);
    end
    return r;
  endfunction

  // Channels strictly above the one currently selected.
  assign higher = mask & (16'hFFFE << a_q);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    a_vld_d  = a_vld_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    wrap_d   = 1'b0;
    cont_d   = cont_q;
    dwell_d  = dwell_q;
    cnt_d    = cnt_q;
    nxt_idx  = (higher != 16'h0) ? lowest(higher) : lowest(mask);
    nxt_wrap = (higher == 16'h0);
    to_idle  = 1'b0;
`ifdef SCAN_BLANK_EN
    pend_idx_d  = pend_idx_q;
    pend_wrap_d = pend_wrap_q;
`endif
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          if (mask == 16'h0) begin
            done_d = 1'b1;
          end else begin
            state_d = DWELL;
            a_d     = lowest(mask);
            a_vld_d = 1'b1;
            busy_d  = 1'b1;
            cnt_d   = '0;
            cont_d  = cont;
            dwell_d = dwell;
          end
        end
      end
      DWELL: begin
        if (stop) begin
          to_idle = 1'b1;
        end else if (cnt_q != dwell_q) begin
          cnt_d = cnt_q + 1'b1;
        end else if (mask == 16'h0 || (nxt_wrap && !cont_q)) begin
          to_idle = 1'b1;
          done_d  = 1'b1;
        end else begin
          cnt_d   = '0;
          dwell_d = dwell;
`ifdef SCAN_BLANK_EN
          state_d     = BLANK;
          a_vld_d     = 1'b0;
          pend_idx_d  = nxt_idx;
          pend_wrap_d = nxt_wrap;
`else
          a_d    = nxt_idx;
          wrap_d = nxt_wrap;
`endif
        end
      end
`ifdef SCAN_BLANK_EN
      BLANK: begin
        if (stop) begin
          to_idle = 1'b1;
        end else begin
          state_d = DWELL;
          a_d     = pend_idx_q;
          a_vld_d = 1'b1;
          wrap_d  = pend_wrap_q;
        end
      end
`endif
      default: to_idle = 1'b1;
    endcase
    if (to_idle) begin
      state_d = IDLE;
      a_d     = '0;
      a_vld_d = 1'b0;
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      a_vld_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
      cont_q  <= 1'b0;
      dwell_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      a_vld_q <= a_vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
      cont_q  <= cont_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SCAN_BLANK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_idx_q  <= '0;
      pend_wrap_q <= 1'b0;
    end else begin
      pend_idx_q  <= pend_idx_d;
      pend_wrap_q <= pend_wrap_d;
    end
  end
`endif

  assign a     = a_q;
  assign a_vld = a_vld_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_scan_index_sequencer.sv
// Randomized bench for scan_index_sequencer: expected per-cycle output lists are built from the mask/dwell rules.
module tb_scan_index_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, cont;
  logic [7:0]  dwell;
  logic [15:0] mask;
  logic [3:0]  a;
  logic        a_vld, busy, done, wrap;
  logic [7:0]  obs;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

`ifdef SCAN_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  scan_index_sequencer #(.DWELL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cont(cont),
    .dwell(dwell), .mask(mask), .a(a), .a_vld(a_vld), .busy(busy),
    .done(done), .wrap(wrap)
  );

  always #5 clk = ~clk;

  assign obs = {a, a_vld, busy, done, wrap};

  function automatic logic [7:0] ent(input int idx, input bit v, input bit b, input bit d, input bit w);
    return {4'(idx), v, b, d, w};
  endfunction

  // Channels in ascending order, each dwell+1 cycles; a new round begins with a wrap pulse.
  task automatic build(input logic [15:0] m, input int d, input int rounds);
    int bits[$];
    int prev;
    exp_q.delete();
    for (int i = 0; i < 16; i++) if (m[i]) bits.push_back(i);
    for (int r = 0; r < rounds; r++) begin
      for (int j = 0; j < bits.size(); j++) begin
        if (BLANK_EN && !(r == 0 && j == 0)) begin
          prev = (j == 0) ? bits[bits.size()-1] : bits[j-1];
          exp_q.push_back(ent(prev, 0, 1, 0, 0));
        end
        for (int k = 0; k <= d; k++)
          exp_q.push_back(ent(bits[j], 1, 1, 0, (r > 0 && j == 0 && k == 0)));
      end
    end
  endtask

  task automatic run_expect(input string name, input int restart_at, input int stop_at);
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (obs !== exp_q[k]) begin
        errors++;
        $display("FAIL %s cycle %0d: {a,vld,busy,done,wrap} got %h want %h", name, k, obs, exp_q[k]);
      end
      start = (k == restart_at);
      cont  = (k == restart_at);
      stop  = (k == stop_at);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; stop = 0; cont = 0; dwell = 0; mask = 0;
    #1;
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL reset_state got %h want 00", obs);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mask = 16'hFFFF; dwell = 8'd3; cont = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_prescan_busy got %b want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL reset_async_clear got %h want 00", obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== 8'h00) begin
        errors++;
        $display("FAIL reset_no_resume cycle %0d got %h want 00", i, obs);
      end
    end
  endtask

  task automatic test_oneshot(input logic [15:0] m, input int d, input int restart_at);
    mask = m; dwell = 8'(d); cont = 1'b0; start = 1'b1; stop = 1'b0;
    build(m, d, 1);
    @(negedge clk);
    start = 1'b0;
    run_expect("oneshot", restart_at, -1);
    checks++;
    if (obs !== ent(0, 0, 0, 1, 0)) begin
      errors++;
      $display("FAIL oneshot_done mask %h got %h want %h", m, obs, ent(0, 0, 0, 1, 0));
    end
    @(negedge clk);
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL oneshot_idle mask %h got %h want 00", m, obs);
    end
  endtask

  task automatic test_cont(input logic [15:0] m, input int d, input int ncyc);
    int pc;
    pc = $countones(m);
    mask = m; dwell = 8'(d); cont = 1'b1; start = 1'b1; stop = 1'b0;
    build(m, d, ncyc / (pc * (d + 1)) + 2);
    while (exp_q.size() > ncyc) void'(exp_q.pop_back());
    @(negedge clk);
    start = 1'b0;
    run_expect("cont", -1, exp_q.size() - 1);
    stop = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs !== 8'h00) begin
        errors++;
        $display("FAIL cont_stop mask %h cycle %0d got %h want 00", m, i, obs);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_edges();
    mask = 16'h0; cont = $urandom_range(0, 1); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (obs !== ent(0, 0, 0, 1, 0)) begin
      errors++;
      $display("FAIL empty_mask_done got %h want %h", obs, ent(0, 0, 0, 1, 0));
    end
    @(negedge clk);
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL empty_mask_idle got %h want 00", obs);
    end
    mask = 16'hFFFF; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL start_stop_same got %h want 00", obs);
    end
    @(negedge clk);
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL start_stop_after got %h want 00", obs);
    end
  endtask

  // Mask drops from 0x00F0 to 0x0003 while channel 4 dwells: no channel above 4 remains.
  task automatic test_mask_change(input bit c);
    mask = 16'h00F0; dwell = 8'd3; cont = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs !== ent(4, 1, 1, 0, 0)) begin
        errors++;
        $display("FAIL mask_change_hold cycle %0d got %h want %h", k, obs, ent(4, 1, 1, 0, 0));
      end
      mask = 16'h0003;
      @(negedge clk);
    end
    if (c) begin
      if (BLANK_EN) begin
        checks++;
        if (obs !== ent(4, 0, 1, 0, 0)) begin
          errors++;
          $display("FAIL mask_change_blank got %h want %h", obs, ent(4, 0, 1, 0, 0));
        end
        @(negedge clk);
      end
      checks++;
      if (obs !== ent(0, 1, 1, 0, 1)) begin
        errors++;
        $display("FAIL mask_change_wrap got %h want %h", obs, ent(0, 1, 1, 0, 1));
      end
      stop = 1'b1;
    end else begin
      checks++;
      if (obs !== ent(0, 0, 0, 1, 0)) begin
        errors++;
        $display("FAIL mask_change_done got %h want %h", obs, ent(0, 0, 0, 1, 0));
      end
    end
    @(negedge clk);
    stop = 1'b0;
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL mask_change_idle got %h want 00", obs);
    end
  endtask

  task automatic test_random();
    logic [15:0] m;
    int d, n;
    for (int it = 0; it < 6; it++) begin
      m = 16'($urandom);
      if (m == 16'h0) m = 16'h0100;
      d = $urandom_range(0, 3);
      n = $countones(m) * (d + 1);
      test_oneshot(m, d, (n > 1) ? int'($urandom_range(0, n - 2)) : -1);
    end
    for (int it = 0; it < 4; it++) begin
      m = 16'($urandom) & 16'($urandom);
      if (m == 16'h0) m = 16'h0021;
      test_cont(m, $urandom_range(0, 2), $urandom_range(10, 60));
    end
  endtask

  initial begin
    test_reset();
    test_oneshot(16'hFFFF, 0, -1);
    test_oneshot(16'h8421, 2, 4);
    test_oneshot(16'h0003, 0, -1);
    test_cont(16'h0006, 1, 14);
    test_cont(16'h0010, 1, 9);
    test_edges();
    test_mask_change(1'b1);
    test_mask_change(1'b0);
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
